channel_pole_scheduler: RTL

Synthesizable, time-multiplexed replacement for the per-pole behavioural channel models. One shared complex pole-update MAC is sequenced across NPOLE first-order complex recursions per input sample. Every pole's coefficients and the direct gain are loaded through a register-write port. The block sits between the TX sample source and the ADC front-end model in the data-generation flow, and produces one channel output per accepted sample, bit-matching a fixed-point golden model of the per-pole equations.

---
 rtl/channel_sched_pkg.sv | 34 +++
 rtl/channel_pole_mac.sv | 35 +++
 rtl/channel_pole_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/channel_sched_pkg.sv
// rtl/channel_sched_pkg.sv - shared types, constants and fixed-point helpers for channel_pole_scheduler
package channel_sched_pkg;
    localparam int NPOLE_DEF = 6;
    localparam int DW_DEF    = 16;
    localparam int CW_DEF    = 18;
    localparam int SW_DEF    = 40;

    localparam int GAIN_R  = 0;
    localparam int GAIN_I  = 1;
    localparam int EXP_R   = 2;
    localparam int EXP_I   = 3;
    localparam int DC_ADDR = 4 * NPOLE_DEF;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

    // Every product and sum in the datapath fits comfortably in 64 signed bits.
    typedef logic signed [63:0] wide_t;

    function automatic wide_t rs(input wide_t v, input int sh);
        wide_t half;
        half = 64'sd1 <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

    function automatic wide_t sat(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction
endpackage

// File: rtl/channel_pole_mac.sv
// rtl/channel_pole_mac.sv - combinational first-order complex pole update with input injection
module channel_pole_mac
    import channel_sched_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic signed [SW-1:0] ac_r,
    input  logic signed [SW-1:0] ac_i,
    input  logic signed [CW-1:0] exp_r,
    input  logic signed [CW-1:0] exp_i,
    input  logic signed [CW-1:0] gain_r,
    input  logic signed [CW-1:0] gain_i,
    input  logic signed [DW-1:0] x,
    output logic signed [SW-1:0] new_r,
    output logic signed [SW-1:0] new_i
);
    wide_t ar, ai, er, ei, gr, gi, xw, sum_r, sum_i;

    always_comb begin
        ar    = wide_t'(ac_r);
        ai    = wide_t'(ac_i);
        er    = wide_t'(exp_r);
        ei    = wide_t'(exp_i);
        gr    = wide_t'(gain_r);
        gi    = wide_t'(gain_i);
        xw    = wide_t'(x);
        // Rotation is rounded back to state scale; the input injection is exact.
        sum_r = rs(er * ar - ei * ai, CW - 1) + gr * xw;
        sum_i = rs(ei * ar + er * ai, CW - 1) + gi * xw;
        new_r = SW'(sat(sum_r, SW));
        new_i = SW'(sat(sum_i, SW));
    end
endmodule

// File: rtl/channel_pole_scheduler.sv
// rtl/channel_pole_scheduler.sv - time-multiplexed NPOLE complex-pole channel model with register config
module channel_pole_scheduler
    import channel_sched_pkg::*;
#(
    parameter int NPOLE = NPOLE_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int SW    = SW_DEF,
    parameter int AW    = $clog2(4 * NPOLE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [CW-1:0]        cfg_data,
    output logic                 cfg_err,
    input  logic                 state_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_y
);
    localparam int PW = (NPOLE > 1) ? $clog2(NPOLE) : 1;
    localparam int YW = SW + $clog2(NPOLE + 1);
    localparam logic [AW-1:0] DC_A = AW'(4 * NPOLE);

    state_t               state;
    logic [PW-1:0]        p;
    logic signed [DW-1:0] x_q;
    logic signed [YW-1:0] yacc;
    logic signed [CW-1:0] dc_gain;
    logic signed [CW-1:0] gain_r [NPOLE];
    logic signed [CW-1:0] gain_i [NPOLE];
    logic signed [CW-1:0] exp_r  [NPOLE];
    logic signed [CW-1:0] exp_i  [NPOLE];
    logic signed [SW-1:0] ac_r   [NPOLE];
    logic signed [SW-1:0] ac_i   [NPOLE];

    logic                 cfg_ok;
    logic signed [CW-1:0] dc_eff;
    logic signed [SW-1:0] mac_r;
    logic signed [SW-1:0] mac_i;
    logic signed [YW-1:0] yacc_next;
    wide_t                y_round;

    assign cfg_ok    = cfg_we && (state == IDLE) && (cfg_addr <= DC_A);
    // A dc_gain write coinciding with an accept must already apply to that sample.
    assign dc_eff    = (cfg_ok && cfg_addr == DC_A) ? cfg_data : dc_gain;
    assign yacc_next = yacc + YW'(ac_r[p]);
    assign y_round   = sat(rs(wide_t'(yacc_next), CW - 1), DW);

    channel_pole_mac #(.DW(DW), .CW(CW), .SW(SW)) u_mac (
        .ac_r   (ac_r[p]),
        .ac_i   (ac_i[p]),
        .exp_r  (exp_r[p]),
        .exp_i  (exp_i[p]),
        .gain_r (gain_r[p]),
        .gain_i (gain_i[p]),
        .x      (x_q),
        .new_r  (mac_r),
        .new_i  (mac_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_y     <= '0;
            cfg_err   <= 1'b0;
            p         <= '0;
            x_q       <= '0;
            yacc      <= '0;
            dc_gain   <= '0;
            for (int i = 0; i < NPOLE; i++) begin
                gain_r[i] <= '0;
                gain_i[i] <= '0;
                exp_r[i]  <= '0;
                exp_i[i]  <= '0;
                ac_r[i]   <= '0;
                ac_i[i]   <= '0;
            end
        end else begin
            if (cfg_we && !cfg_ok) cfg_err <= 1'b1;
            if (cfg_ok) begin
                if (cfg_addr == DC_A) begin
                    dc_gain <= cfg_data;
                end else begin
                    for (int i = 0; i < NPOLE; i++) begin
                        if (cfg_addr[AW-1:2] == (AW-2)'(i)) begin
                            case (cfg_addr[1:0])
                                2'(GAIN_R): gain_r[i] <= cfg_data;
                                2'(GAIN_I): gain_i[i] <= cfg_data;
                                2'(EXP_R):  exp_r[i]  <= cfg_data;
                                default:    exp_i[i]  <= cfg_data;
                            endcase
                        end
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (state_clr) begin
                        for (int i = 0; i < NPOLE; i++) begin
                            ac_r[i] <= '0;
                            ac_i[i] <= '0;
                        end
                    end
                    if (in_valid) begin
                        x_q      <= in_x;
                        yacc     <= YW'(wide_t'(dc_eff) * wide_t'(in_x));
                        p        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Output accumulates the pre-update state: one-sample delay per pole.
                    yacc    <= yacc_next;
                    ac_r[p] <= mac_r;
                    ac_i[p] <= mac_i;
                    if (p == PW'(NPOLE - 1)) begin
                        out_y     <= DW'(y_round);
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        p <= p + PW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
